// File: rtl/ifid_skid_reg.sv
// IF/ID pipeline register with valid/ready handshake, 2-entry skid buffer, flush and
// registered MIPS field decode. Optional stall counter enabled by `define IFID_PERF_CNT_EN.
module ifid_skid_reg #(
   parameter int unsigned PC_W   = 32,
   parameter int unsigned INST_W = 32,  // field slicing assumes 32-bit MIPS encoding
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PC_W-1:0]   in_pc4,
   input  logic [INST_W-1:0] in_inst,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc4,
   output logic [5:0]        op,
   output logic [4:0]        rs,
   output logic [4:0]        rt,
   output logic [4:0]        rd,
   output logic [4:0]        shamt,
   output logic [5:0]        funct,
   output logic [15:0]       imm
`ifdef IFID_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt
`endif
);

   logic              main_valid_q, main_valid_d;
   logic              skid_valid_q, skid_valid_d;
   logic [PC_W-1:0]   main_pc4_q, main_pc4_d;
   logic [PC_W-1:0]   skid_pc4_q, skid_pc4_d;
   logic [INST_W-1:0] skid_inst_q, skid_inst_d;
   logic [5:0]        op_q, op_d;
   logic [4:0]        rs_q, rs_d;
   logic [4:0]        rt_q, rt_d;
   logic [4:0]        rd_q, rd_d;
   logic [4:0]        shamt_q, shamt_d;
   logic [5:0]        funct_q, funct_d;
   logic [15:0]       imm_q, imm_d;

   logic              in_fire;
   logic              out_fire;
   logic              load_main;
   logic              main_from_skid;
   logic              load_skid;
   logic              clear_main;
   logic [PC_W-1:0]   sel_pc4;
   logic [INST_W-1:0] sel_inst;

   // in_ready depends on state only, so out_ready never reaches fetch combinationally.
   assign in_ready  = !skid_valid_q;
   assign out_valid = main_valid_q;
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = main_valid_q && out_ready;

   always_comb begin
      main_valid_d   = main_valid_q;
      skid_valid_d   = skid_valid_q;
      load_main      = 1'b0;
      main_from_skid = 1'b0;
      load_skid      = 1'b0;
      clear_main     = 1'b0;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
         clear_main   = 1'b1;
      end else if (!main_valid_q) begin
         if (in_fire) begin
            main_valid_d = 1'b1;
            load_main    = 1'b1;
         end
      end else if (skid_valid_q) begin
         if (out_fire) begin
            load_main      = 1'b1;
            main_from_skid = 1'b1;
            skid_valid_d   = 1'b0;
         end
      end else if (out_fire) begin
         if (in_fire) begin
            load_main = 1'b1;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (in_fire) begin
         skid_valid_d = 1'b1;
         load_skid    = 1'b1;
      end
   end

   assign sel_pc4  = main_from_skid ? skid_pc4_q  : in_pc4;
   assign sel_inst = main_from_skid ? skid_inst_q : in_inst;

   always_comb begin
      main_pc4_d  = main_pc4_q;
      op_d        = op_q;
      rs_d        = rs_q;
      rt_d        = rt_q;
      rd_d        = rd_q;
      shamt_d     = shamt_q;
      funct_d     = funct_q;
      imm_d       = imm_q;
      skid_pc4_d  = skid_pc4_q;
      skid_inst_d = skid_inst_q;
      if (clear_main) begin
         // Flushed main presents a NOP encoding.
         main_pc4_d = '0;
         op_d       = '0;
         rs_d       = '0;
         rt_d       = '0;
         rd_d       = '0;
         shamt_d    = '0;
         funct_d    = '0;
         imm_d      = '0;
      end else if (load_main) begin
         main_pc4_d = sel_pc4;
         op_d       = sel_inst[31:26];
         rs_d       = sel_inst[25:21];
         rt_d       = sel_inst[20:16];
         rd_d       = sel_inst[15:11];
         shamt_d    = sel_inst[10:6];
         funct_d    = sel_inst[5:0];
         imm_d      = sel_inst[15:0];
      end
      if (load_skid) begin
         skid_pc4_d  = in_pc4;
         skid_inst_d = in_inst;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         main_pc4_q   <= '0;
         skid_pc4_q   <= '0;
         skid_inst_q  <= '0;
         op_q         <= '0;
         rs_q         <= '0;
         rt_q         <= '0;
         rd_q         <= '0;
         shamt_q      <= '0;
         funct_q      <= '0;
         imm_q        <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         main_pc4_q   <= main_pc4_d;
         skid_pc4_q   <= skid_pc4_d;
         skid_inst_q  <= skid_inst_d;
         op_q         <= op_d;
         rs_q         <= rs_d;
         rt_q         <= rt_d;
         rd_q         <= rd_d;
         shamt_q      <= shamt_d;
         funct_q      <= funct_d;
         imm_q        <= imm_d;
      end
   end

   assign out_pc4 = main_pc4_q;
   assign op      = op_q;
   assign rs      = rs_q;
   assign rt      = rt_q;
   assign rd      = rd_q;
   assign shamt   = shamt_q;
   assign funct   = funct_q;
   assign imm     = imm_q;

`ifdef IFID_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // Saturating count of stalled decode cycles; flush cycles are not counted.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!flush && main_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ifid_skid_reg.sv
// Self-checking bench for ifid_skid_reg: directed handshake/flush/reset scenarios plus a
// scoreboarded random stream. Stall counter checks run when IFID_PERF_CNT_EN is defined.
module tb_ifid_skid_reg;

`ifdef IFID_PERF_CNT_EN
   localparam int unsigned CNT_W = 4;
`else
   localparam int unsigned CNT_W = 16;
`endif

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
   logic [31:0] in_pc4, in_inst, out_pc4;
   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm;
`ifdef IFID_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt;
`endif

   ifid_skid_reg #(.PC_W(32), .INST_W(32), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pc4    (in_pc4),
      .in_inst   (in_inst),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pc4   (out_pc4),
      .op        (op),
      .rs        (rs),
      .rt        (rt),
      .rd        (rd),
      .shamt     (shamt),
      .funct     (funct),
      .imm       (imm)
`ifdef IFID_PERF_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          passes = 0;
   logic [63:0] sb[$];
   logic        in_fire, out_fire;
   logic [31:0] obs_pc4, obs_inst;
   logic [15:0] obs_imm;

   // Sample handshake and outputs mid-cycle, then advance past the next rising edge.
   task automatic tick();
      @(negedge clk);
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      obs_pc4  = out_pc4;
      obs_inst = {op, rs, rt, rd, shamt, funct};
      obs_imm  = imm;
      if (in_fire && !flush && !rst) sb.push_back({in_pc4, in_inst});
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid  = 1'b0;
      in_pc4    = '0;
      in_inst   = '0;
      flush     = 1'b0;
      out_ready = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb.delete();
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         $display("FAIL reset_hs: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
      end else passes++;
      checks++;
      if ({out_pc4, op, rs, rt, rd, shamt, funct, imm} !== '0) begin
         $display("FAIL reset_data: pc4=%h op=%h imm=%h, want all 0", out_pc4, op, imm);
      end else passes++;
`ifdef IFID_PERF_CNT_EN
      checks++;
      if (stall_cnt !== '0) $display("FAIL reset_cnt: got %0d want 0", stall_cnt);
      else passes++;
`endif
   endtask

   task automatic test_pass_through();
      do_reset();
      in_valid  = 1'b1;
      in_pc4    = 32'h4;
      in_inst   = 32'h012A4020;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_pc4 !== 32'h4 || op !== 6'd0 || rs !== 5'd9 ||
          rt !== 5'd10 || rd !== 5'd8 || shamt !== 5'd0 || funct !== 6'h20 ||
          imm !== 16'h4020) begin
         $display("FAIL pass_add: v=%b pc4=%h op=%h rs=%0d rt=%0d rd=%0d sh=%0d fn=%h imm=%h",
                  out_valid, out_pc4, op, rs, rt, rd, shamt, funct, imm);
      end else passes++;
      tick();
      checks++;
      if (out_valid !== 1'b0) $display("FAIL pass_drain: out_valid=%b want 0", out_valid);
      else passes++;
   endtask

   task automatic test_skid();
      do_reset();
      in_valid = 1'b1;
      in_pc4   = 32'h10;
      in_inst  = 32'h20080001;
      tick();
      in_pc4  = 32'h8;
      in_inst = 32'h8D090004;
      tick();
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc4 !== 32'h10) begin
         $display("FAIL skid_fill: in_ready=%b out_valid=%b pc4=%h, want 0 1 10",
                  in_ready, out_valid, out_pc4);
      end else passes++;
      out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (!out_fire || sb.size() == 0) begin
            $display("FAIL skid_order%0d: fire=%b queued=%0d, want beat", i, out_fire, sb.size());
         end else if ({obs_pc4, obs_inst} !== sb[0]) begin
            $display("FAIL skid_order%0d: got %h want %h", i, {obs_pc4, obs_inst}, sb[0]);
            void'(sb.pop_front());
         end else begin
            passes++;
            void'(sb.pop_front());
         end
         if (i == 0) begin
            checks++;
            if (op !== 6'h23 || imm !== 16'h0004 || in_ready !== 1'b1) begin
               $display("FAIL skid_lw: op=%h imm=%h in_ready=%b, want 23 0004 1",
                        op, imm, in_ready);
            end else passes++;
         end
      end
      checks++;
      if (out_valid !== 1'b0) $display("FAIL skid_empty: out_valid=%b want 0", out_valid);
      else passes++;
   endtask

   task automatic test_hold();
      do_reset();
      in_valid = 1'b1;
      in_pc4   = 32'h20;
      in_inst  = 32'hAC0B0010;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_pc4 !== 32'h20 || {op, rs, rt, rd, shamt, funct} !==
             32'hAC0B0010 || imm !== 16'h0010) begin
            $display("FAIL hold%0d: v=%b pc4=%h op=%h imm=%h, want 1 20 2b 0010",
                     i, out_valid, out_pc4, op, imm);
         end else passes++;
      end
`ifdef IFID_PERF_CNT_EN
      checks++;
      if (stall_cnt !== 4'd5) $display("FAIL hold_cnt: got %0d want 5", stall_cnt);
      else passes++;
`endif
   endtask

   task automatic test_flush();
      do_reset();
      in_valid = 1'b1;
      in_pc4   = 32'h30;
      in_inst  = 32'h01095020;
      tick();
      in_pc4  = 32'h34;
      in_inst = 32'h01095022;
      tick();
      in_pc4  = 32'h38;
      in_inst = 32'h3C01BEEF;
      flush   = 1'b1;
      tick();
      flush = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
          {out_pc4, op, rs, rt, rd, shamt, funct, imm} !== '0) begin
         $display("FAIL flush_full: v=%b rdy=%b pc4=%h op=%h imm=%h, want 0 1 0 0 0",
                  out_valid, in_ready, out_pc4, op, imm);
      end else passes++;
`ifdef IFID_PERF_CNT_EN
      checks++;
      if (stall_cnt !== 4'd1) $display("FAIL flush_cnt: got %0d want 1", stall_cnt);
      else passes++;
`endif
      // Main full, skid empty: the beat offered alongside flush must be dropped.
      in_pc4  = 32'h40;
      in_inst = 32'h11110001;
      tick();
      in_pc4  = 32'h44;
      in_inst = 32'h22220002;
      flush   = 1'b1;
      tick();
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      sb.delete();
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (out_fire) $display("FAIL flush_drop%0d: got beat pc4=%h want none", i, obs_pc4);
         else passes++;
      end
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_pc4  = 32'h100 + 32'(4 * i);
         in_inst = 32'hCAFE0000 + 32'(i);
         tick();
      end
      in_valid = 1'b0;
      rst      = 1'b1;
      tick();
      rst = 1'b0;
      sb.delete();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         $display("FAIL rst_stall: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
      end else passes++;
`ifdef IFID_PERF_CNT_EN
      checks++;
      if (stall_cnt !== '0) $display("FAIL rst_stall_cnt: got %0d want 0", stall_cnt);
      else passes++;
`endif
   endtask

   task automatic test_back_to_back();
      int fires = 0;
      do_reset();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 9; i++) begin
         in_pc4  = 32'h200 + 32'(4 * i);
         in_inst = $urandom();
         if (i == 8) in_valid = 1'b0;
         tick();
         if (i < 8) begin
            checks++;
            if (!in_fire) $display("FAIL b2b_accept%0d: in_ready=0 want 1", i);
            else passes++;
         end
         if (out_fire) begin
            fires++;
            checks++;
            if (sb.size() == 0) $display("FAIL b2b_data: got %h want none", obs_pc4);
            else if ({obs_pc4, obs_inst} !== sb[0] || obs_imm !== sb[0][15:0])
               $display("FAIL b2b_data: got %h want %h", {obs_pc4, obs_inst}, sb.pop_front());
            else begin
               passes++;
               void'(sb.pop_front());
            end
         end
      end
      checks++;
      if (fires != 8) $display("FAIL b2b_count: got %0d beats want 8", fires);
      else passes++;
   endtask

   task automatic test_random_stream();
      int errs = 0;
      do_reset();
      for (int i = 0; i < 300; i++) begin
         in_valid  = ($urandom_range(9) < 7);
         out_ready = ($urandom_range(9) < 6);
         in_pc4    = $urandom();
         in_inst   = $urandom();
         if (i >= 290) in_valid = 1'b0;
         if (i >= 290) out_ready = 1'b1;
         tick();
         if (out_fire) begin
            checks++;
            if (sb.size() == 0) begin
               $display("FAIL rand_beat%0d: got %h want none", i, obs_pc4);
            end else if ({obs_pc4, obs_inst} !== sb[0] || obs_imm !== sb[0][15:0]) begin
               if (errs < 5) $display("FAIL rand_beat%0d: got %h want %h", i,
                                      {obs_pc4, obs_inst}, sb[0]);
               errs++;
               void'(sb.pop_front());
            end else begin
               passes++;
               void'(sb.pop_front());
            end
         end
      end
      checks++;
      if (sb.size() != 0) $display("FAIL rand_drain: got %0d left want 0", sb.size());
      else passes++;
   endtask

`ifdef IFID_PERF_CNT_EN
   task automatic test_saturation();
      do_reset();
      in_valid = 1'b1;
      in_pc4   = 32'h300;
      in_inst  = 32'h00000000;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      checks++;
      if (stall_cnt !== 4'd15) $display("FAIL sat20: got %0d want 15", stall_cnt);
      else passes++;
      for (int i = 0; i < 3; i++) tick();
      checks++;
      if (stall_cnt !== 4'd15) $display("FAIL sat_hold: got %0d want 15", stall_cnt);
      else passes++;
   endtask
`endif

   initial begin
      idle_inputs();
      rst = 1'b1;
      test_reset();
      test_pass_through();
      test_skid();
      test_hold();
      test_flush();
      test_reset_mid_stall();
      test_back_to_back();
      test_random_stream();
`ifdef IFID_PERF_CNT_EN
      test_saturation();
`endif
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
